// File: rtl/freq_meter_pkg.sv
// Shared definitions for the period/high-time meter and the display formatter.
// State codes are plain localparams so non-SV consumers can decode the raw value.
package freq_meter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;
    localparam logic [1:0] ST_TMO  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StArm  = ST_ARM,
        StMeas = ST_MEAS,
        StTmo  = ST_TMO
    } state_e;

endpackage

// File: rtl/edge_sync.sv
// Synchroniser for an asynchronous input with registered rise/fall pulses
// taken from the two oldest synchroniser stages.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            fall_q <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/freq_period_meter.sv
// Measures period and high time of an asynchronous square wave in clock cycles,
// averaged over 2**AVG_LOG2 periods, with a dead-input timeout.
module freq_period_meter #(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 50_000_000
) (
    input  logic             MAX10_CLK1_50,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             result_valid,
    output logic             timeout
);
    import freq_meter_pkg::*;

    localparam int unsigned      ACC_W   = CNT_W + AVG_LOG2;
    localparam int unsigned      N_W     = AVG_LOG2 + 1;
    localparam logic [N_W-1:0]   N_LAST  = N_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);

    logic rise, fall;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (MAX10_CLK1_50),
        .rst_n  (reset),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]   hi_smp_q, hi_smp_d;
    logic [ACC_W-1:0]   per_acc_q, per_acc_d, hi_acc_q, hi_acc_d, per_sum, hi_sum;
    logic [N_W-1:0]     n_q, n_d;
    logic [CNT_W-1:0]   period_q, period_d, high_q, high_d;
    logic               valid_q, valid_d, tmo_q, tmo_d;

    assign cnt_inc = cnt_q + 1'b1;
    assign per_sum = per_acc_q + ACC_W'(cnt_inc);
    assign hi_sum  = hi_acc_q + ACC_W'(hi_smp_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_smp_d  = hi_smp_q;
        per_acc_d = per_acc_q;
        hi_acc_d  = hi_acc_q;
        n_d       = n_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        tmo_d     = tmo_q;

        if (!enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            per_acc_d = '0;
            hi_acc_d  = '0;
            n_d       = '0;
            tmo_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
                StArm, StMeas: begin
                    if (state_q == StMeas && fall) begin
                        hi_smp_d = cnt_inc;
                    end
                    if (rise) begin
                        cnt_d   = '0;
                        state_d = StMeas;
                        if (state_q == StMeas) begin
                            // Last sample of the window: publish and restart in one cycle.
                            if (n_q == N_LAST) begin
                                period_d  = CNT_W'(per_sum >> AVG_LOG2);
                                high_d    = CNT_W'(hi_sum >> AVG_LOG2);
                                valid_d   = 1'b1;
                                per_acc_d = '0;
                                hi_acc_d  = '0;
                                n_d       = '0;
                            end else begin
                                per_acc_d = per_sum;
                                hi_acc_d  = hi_sum;
                                n_d       = n_q + 1'b1;
                            end
                        end
                    end else if (cnt_inc == CNT_TMO) begin
                        state_d   = StTmo;
                        tmo_d     = 1'b1;
                        cnt_d     = '0;
                        per_acc_d = '0;
                        hi_acc_d  = '0;
                        n_d       = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StTmo: begin
                    if (rise) begin
                        state_d = StMeas;
                        tmo_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_smp_q  <= '0;
            per_acc_q <= '0;
            hi_acc_q  <= '0;
            n_q       <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_smp_q  <= hi_smp_d;
            per_acc_q <= per_acc_d;
            hi_acc_q  <= hi_acc_d;
            n_q       <= n_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign result_valid = valid_q;
    assign timeout      = tmo_q;

endmodule
